signed_sub_with_overflow_serial: RTL and testbench

- Multi-cycle signed (two's complement) subtractor: diff = a - b, with an overflow flag.
- Processes CHUNK bits per clock, LSB chunk first, carrying between chunks. Latency is traded for a narrow adder.
- Valid/ready on the operand side and the result side. It sits beside the combinational signed adder in the arithmetic library and covers the subtract direction for wide operands.

---
 rtl/signed_sub_with_overflow_serial.sv | 132 +++++++++++++
 tb/tb_signed_sub_with_overflow_serial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_sub_with_overflow_serial.sv
`default_nettype none
// ============================================================================
// Module   : signed_sub_with_overflow_serial
// Brief    : Chunk-serial two's complement subtractor (diff = a - b) with
//            signed overflow flag and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module signed_sub_with_overflow_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] diff,
    output logic             overflow
);

    localparam int c_NCH = WIDTH / CHUNK;
    localparam int c_CW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_nb;
    logic [WIDTH-1:0]  r_diff;
    logic              r_ovf;

    int                w_base;
    logic              w_last;
    logic [CHUNK-1:0]  w_a_chk;
    logic [CHUNK-1:0]  w_b_chk;
    logic [CHUNK:0]    w_sum;
    logic              w_accept;

    assign w_base   = int'(r_cnt) * CHUNK;
    assign w_last   = (r_cnt == c_CW'(c_NCH - 1));
    assign w_a_chk  = r_a[w_base +: CHUNK];
    assign w_b_chk  = r_nb[w_base +: CHUNK];
    assign w_sum    = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
    assign w_accept = arg_vld & arg_rdy;

    assign diff     = r_diff;
    assign overflow = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arg_rdy     = 1'b0;
        res_vld     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // b is stored inverted so each chunk step is a plain add; carry=1 supplies the +1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_nb    <= '0;
            r_diff  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    r_diff[w_base +: CHUNK] <= w_sum[CHUNK-1:0];
                    r_carry                 <= w_sum[CHUNK];
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Operand signs equal after inverting b means a and b differ in sign.
                        r_ovf <= (r_a[WIDTH-1] == r_nb[WIDTH-1]) &
                                 (w_sum[CHUNK-1] != r_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_sub_with_overflow_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_sub_with_overflow_serial
// Brief    : Directed table, corner sequences and randomized checking of the
//            chunk-serial signed subtractor for CHUNK = 1, 4 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_sub_with_overflow_serial;

    localparam int NOPS = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic go = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed instance (CHUNK = 4)
    logic        rst_d = 1'b0;
    logic        d_vld = 1'b0;
    logic        d_ardy;
    logic [15:0] d_a = '0;
    logic [15:0] d_b = '0;
    logic        d_rvld;
    logic        d_rrdy = 1'b0;
    logic [15:0] d_diff;
    logic        d_ovf;

    signed_sub_with_overflow_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst_d), .arg_vld(d_vld), .arg_rdy(d_ardy),
        .a(d_a), .b(d_b), .res_vld(d_rvld), .res_rdy(d_rrdy),
        .diff(d_diff), .overflow(d_ovf)
    );

    // Randomized instances
    logic rst_r = 1'b0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        localparam int N  = 16 / CH;
        logic        vld, ardy, rvld, rrdy, ovf, done;
        logic [15:0] ra, rb, dif;

        signed_sub_with_overflow_serial #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk(clk), .rst(rst_r), .arg_vld(vld), .arg_rdy(ardy),
            .a(ra), .b(rb), .res_vld(rvld), .res_rdy(rrdy),
            .diff(dif), .overflow(ovf)
        );

        initial begin : p_drv
            logic [15:0] ta, tb;
            logic [15:0] ed;
            logic        eo;
            int          lat;
            int          tru;
            done = 1'b0; vld = 1'b0; rrdy = 1'b0; ra = '0; rb = '0;
            wait (go);
            for (int k = 0; k < NOPS; k++) begin
                ta = 16'($urandom);
                tb = 16'($urandom);
                @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra = ta; rb = tb; vld = 1'b1;
                @(posedge clk); #1;
                vld = 1'($urandom_range(0, 1));
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                lat = 0;
                while (!rvld && lat < N + 4) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk("rnd_latency", 32'(lat), 32'(N));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                tru = int'($signed(ta)) - int'($signed(tb));
                ed  = ta - tb;
                eo  = (tru > 32767) || (tru < -32768);
                chk("rnd_diff", 32'(dif), 32'(ed));
                chk("rnd_ovf", 32'(ovf), 32'(eo));
                chk("rnd_vld_held", 32'(rvld), 32'd1);
                rrdy = 1'b1;
                @(posedge clk); #1;
                rrdy = 1'b0; vld = 1'b0;
            end
            done = 1'b1;
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        o;
    } vec_t;

    vec_t vecs [10];

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] dv, output logic ov, output int lat);
        @(negedge clk);
        d_a = a; d_b = b; d_vld = 1'b1;
        @(posedge clk); #1;
        d_vld = 1'b0; d_a = 16'hDEAD; d_b = 16'hBEEF;
        lat = 0;
        while (!d_rvld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        dv = d_diff; ov = d_ovf;
        d_rrdy = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : p_main
        logic [15:0] dv;
        logic        ov;
        int          lat;
        int          t;
        logic        seen;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b1};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0};
        vecs[4] = '{16'h0000, 16'h8000, 16'h8000, 1'b1};
        vecs[5] = '{16'h1234, 16'h1234, 16'h0000, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
        vecs[9] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b0};

        #3;
        rst_d = 1'b1; rst_r = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_diff", 32'(d_diff), 32'h0);
        chk("rst_ovf", 32'(d_ovf), 32'h0);
        chk("rst_res_vld", 32'(d_rvld), 32'h0);
        chk("rst_arg_rdy", 32'(d_ardy), 32'h1);
        rst_d = 1'b0; rst_r = 1'b0;
        go = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, dv, ov, lat);
            chk("tbl_latency", 32'(lat), 32'd4);
            chk("tbl_diff", 32'(dv), 32'(vecs[i].d));
            chk("tbl_ovf", 32'(ov), 32'(vecs[i].o));
            chk("tbl_idle_rdy", 32'(d_ardy), 32'h1);
        end

        // Backpressure with arg_vld held high throughout
        @(negedge clk);
        d_rrdy = 1'b0;
        d_a = 16'h0005; d_b = 16'h0003; d_vld = 1'b1;
        @(posedge clk); #1;
        d_a = 16'h0100; d_b = 16'h0001;
        chk("bp_busy_rdy", 32'(d_ardy), 32'h0);
        lat = 0;
        while (!d_rvld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_res_vld", 32'(d_rvld), 32'h1);
            chk("bp_diff", 32'(d_diff), 32'h0002);
            chk("bp_ovf", 32'(d_ovf), 32'h0);
            chk("bp_arg_rdy", 32'(d_ardy), 32'h0);
        end
        @(negedge clk);
        d_rrdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_vld", 32'(d_rvld), 32'h0);
        chk("bp_rel_rdy", 32'(d_ardy), 32'h1);
        @(posedge clk); #1;
        d_vld = 1'b0;
        chk("bp_next_accept", 32'(d_ardy), 32'h0);
        lat = 0;
        while (!d_rvld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_next_diff", 32'(d_diff), 32'h00FF);
        chk("bp_next_ovf", 32'(d_ovf), 32'h0);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle
        @(negedge clk);
        d_a = 16'h8000; d_b = 16'h0001; d_vld = 1'b1;
        @(posedge clk); #1;
        d_vld = 1'b0;
        @(posedge clk); #2;
        rst_d = 1'b1;
        #1;
        chk("arst_res_vld", 32'(d_rvld), 32'h0);
        chk("arst_arg_rdy", 32'(d_ardy), 32'h1);
        chk("arst_diff", 32'(d_diff), 32'h0);
        @(negedge clk);
        rst_d = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (d_rvld) seen = 1'b1;
        end
        chk("arst_no_result", 32'(seen), 32'h0);
        do_op(16'h7FFF, 16'h8000, dv, ov, lat);
        chk("arst_after_lat", 32'(lat), 32'd4);
        chk("arst_after_diff", 32'(dv), 32'hFFFF);
        chk("arst_after_ovf", 32'(ov), 32'h1);

        t = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        chk("rnd_complete", 32'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
